// File: rtl/branch_resolve_pkg.sv
// Shared types and helpers for execute-stage branch resolution and the
// direction-prediction history table.
package branch_resolve_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } br_state_t;

    localparam bht_ctr_t    BHT_RESET = WNT;
    localparam logic [31:0] CTR_MAX   = 32'hFFFF_FFFF;

    // 2-bit saturating step toward the observed direction
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : bht_ctr_t'(c + 2'd1);
        else
            return (c == SNT) ? SNT : bht_ctr_t'(c - 2'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CTR_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port for fetch and one update port for resolved conditional branches.
module branch_resolve_bht
    import branch_resolve_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_ctr_t ctr [0:(1<<IDX_W)-1];

    // No write-to-read bypass: an aliasing read sees the pre-update value
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << IDX_W); i++)
                ctr[i] <= BHT_RESET;
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control transfers in EX, compares against the fetch prediction and
// issues a registered redirect/flush on mispredict; owns the BHT and perf counters.
//
// state   | meaning
// IDLE    | resolving EX instructions each non-stalled valid cycle
// PENDING | redirect held for fetch; EX contents are wrong-path and ignored
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_br,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        ex_is_c,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        ex_br_en,
    input  logic        ex_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    br_state_t   state;
    bht_ctr_t    pred_ctr;
    logic        resolve;
    logic        taken;
    logic        mispredict;
    logic [31:0] target;
    logic [31:0] fall_thru;
    logic [31:0] correct_pc;
    logic        unused_pred_pc;

    assign unused_pred_pc = ^{pred_pc[31:BHT_IDX_W+1], pred_pc[0]};

    assign resolve    = ex_valid & ~ex_stall & (state == IDLE);
    assign taken      = ex_is_br ? ex_br_en : (ex_is_jal | ex_is_jalr);
    assign target     = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign fall_thru  = ex_pc + (ex_is_c ? 32'd2 : 32'd4);
    assign correct_pc = taken ? target : fall_thru;
    // JALR has no BTB behind it, so fetch never had the right target
    assign mispredict = ex_is_jalr | ((ex_is_br | ex_is_jal) & (taken != ex_pred_taken));

    branch_resolve_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_pc[BHT_IDX_W:1]),
        .rd_ctr    (pred_ctr),
        .upd_en    (resolve & ex_is_br),
        .upd_idx   (ex_pc[BHT_IDX_W:1]),
        .upd_taken (ex_br_en)
    );

    assign pred_taken = (pred_ctr == WT) || (pred_ctr == ST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            flush <= 1'b0;
            if (state == IDLE) begin
                if (resolve & ex_is_br)
                    br_count <= sat_inc(br_count);
                if (resolve & mispredict) begin
                    state          <= PENDING;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= correct_pc;
                    flush          <= 1'b1;
                    mispred_count  <= sat_inc(mispred_count);
                end
            end else if (redirect_ready) begin
                state          <= IDLE;
                redirect_valid <= 1'b0;
            end
        end
    end

    a_ctl_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        ex_valid |-> $onehot0({ex_is_br, ex_is_jal, ex_is_jalr}));

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_br;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_is_c;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        ex_br_en;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    branch_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_br       (ex_is_br),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_is_c        (ex_is_c),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_br_en       (ex_br_en),
        .ex_pred_taken  (ex_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic c,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic en, input logic pred);
        ex_valid      = 1'b1;
        ex_is_br      = br;
        ex_is_jal     = jal;
        ex_is_jalr    = jalr;
        ex_is_c       = c;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rs1        = rs1;
        ex_br_en      = en;
        ex_pred_taken = pred;
    endtask

    task automatic idle_ex;
        ex_valid   = 1'b0;
        ex_stall   = 1'b0;
        ex_is_br   = 1'b0;
        ex_is_jal  = 1'b0;
        ex_is_jalr = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        chk(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        redirect_ready = 1'b0;
        pred_pc = 32'h100;
        ex_is_c = 1'b0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
        ex_br_en = 1'b0; ex_pred_taken = 1'b0;
        idle_ex();
        #12;
        chk("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_br",    br_count, 32'd0);
        chk("rst_mis",   mispred_count, 32'd0);
        probe("rst_pred_100", 32'h100, 1'b0);
        probe("rst_pred_3e",  32'h3e, 1'b0);
        rst_n = 1'b1;
        tick();

        // BNE taken, predicted not-taken
        drive(1, 0, 0, 0, 32'h100, 32'h40, 32'h0, 1, 0);
        probe("alias_pre_update", 32'h100, 1'b0);
        tick();
        idle_ex();
        chk("bne_rv",    {31'd0, redirect_valid}, 32'd1);
        chk("bne_rpc",   redirect_pc, 32'h140);
        chk("bne_flush", {31'd0, flush}, 32'd1);
        chk("bne_mis",   mispred_count, 32'd1);
        chk("bne_br",    br_count, 32'd1);
        probe("bne_pred", 32'h100, 1'b1);
        tick();
        chk("bne_flush2", {31'd0, flush}, 32'd0);
        chk("bne_rv2",    {31'd0, redirect_valid}, 32'd1);
        redirect_ready = 1'b1;
        tick();
        chk("bne_rv_drop", {31'd0, redirect_valid}, 32'd0);

        // compressed BEQ not taken, predicted taken
        drive(1, 0, 0, 1, 32'h200, 32'h40, 32'h0, 0, 1);
        tick();
        idle_ex();
        chk("beq_rv",  {31'd0, redirect_valid}, 32'd1);
        chk("beq_rpc", redirect_pc, 32'h202);
        chk("beq_mis", mispred_count, 32'd2);
        tick();
        chk("beq_rv_drop", {31'd0, redirect_valid}, 32'd0);

        // drive counter to SNT and beyond: must not wrap to ST
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 32'h200, 32'h40, 32'h0, 0, 0);
            tick();
        end
        idle_ex();
        chk("sat0_rv",  {31'd0, redirect_valid}, 32'd0);
        chk("sat0_br",  br_count, 32'd5);
        chk("sat0_mis", mispred_count, 32'd2);
        probe("sat0_pred", 32'h200, 1'b0);

        // BLT taken/predicted taken 4x, then one correctly predicted not-taken
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 32'h10, 32'h8, 32'h0, 1, 1);
            tick();
        end
        drive(1, 0, 0, 0, 32'h10, 32'h8, 32'h0, 0, 0);
        tick();
        idle_ex();
        chk("sat3_rv",  {31'd0, redirect_valid}, 32'd0);
        chk("sat3_br",  br_count, 32'd10);
        chk("sat3_mis", mispred_count, 32'd2);
        probe("sat3_pred", 32'h10, 1'b1);

        // correctly predicted JAL
        drive(0, 1, 0, 0, 32'h300, 32'h80, 32'h0, 0, 1);
        tick();
        idle_ex();
        chk("jal_rv",  {31'd0, redirect_valid}, 32'd0);
        chk("jal_br",  br_count, 32'd10);
        chk("jal_mis", mispred_count, 32'd2);

        // JALR always redirects; held with ready low, wrong-path EX ignored
        redirect_ready = 1'b0;
        drive(0, 0, 1, 0, 32'h400, 32'h10, 32'h1001, 0, 1);
        tick();
        chk("jalr_rv",    {31'd0, redirect_valid}, 32'd1);
        chk("jalr_rpc",   redirect_pc, 32'h1010);
        chk("jalr_flush", {31'd0, flush}, 32'd1);
        chk("jalr_mis",   mispred_count, 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 32'h20, 32'h100, 32'h0, 1, 0);
            tick();
            chk("pend_rv",    {31'd0, redirect_valid}, 32'd1);
            chk("pend_rpc",   redirect_pc, 32'h1010);
            chk("pend_flush", {31'd0, flush}, 32'd0);
            chk("pend_mis",   mispred_count, 32'd3);
            chk("pend_br",    br_count, 32'd10);
        end
        idle_ex();
        redirect_ready = 1'b1;
        tick();
        chk("jalr_rv_drop", {31'd0, redirect_valid}, 32'd0);
        probe("pend_no_bht", 32'h20, 1'b0);

        // BGEU target wraps past 2^32
        drive(1, 0, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1, 0);
        tick();
        idle_ex();
        chk("wrap_rv",  {31'd0, redirect_valid}, 32'd1);
        chk("wrap_rpc", redirect_pc, 32'h0000_0010);
        chk("wrap_mis", mispred_count, 32'd4);
        chk("wrap_br",  br_count, 32'd11);
        tick();

        // stalled mispredicting branch has no effect
        drive(1, 0, 0, 0, 32'h40, 32'h20, 32'h0, 1, 0);
        ex_stall = 1'b1;
        tick();
        tick();
        idle_ex();
        chk("stall_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("stall_flush", {31'd0, flush}, 32'd0);
        chk("stall_br",    br_count, 32'd11);
        chk("stall_mis",   mispred_count, 32'd4);
        probe("stall_pred", 32'h40, 1'b0);

        // reset while a redirect is pending
        redirect_ready = 1'b0;
        drive(1, 0, 0, 0, 32'h100, 32'h40, 32'h0, 1, 0);
        tick();
        idle_ex();
        chk("prerst_rv",  {31'd0, redirect_valid}, 32'd1);
        chk("prerst_mis", mispred_count, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_rpc",   redirect_pc, 32'd0);
        chk("midrst_br",    br_count, 32'd0);
        chk("midrst_mis",   mispred_count, 32'd0);
        probe("midrst_pred", 32'h10, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_rv", {31'd0, redirect_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
